// File: rtl/pixel_readout_sequencer_pkg.sv
// Shared types and helpers for the pixel readout sequencer: FSM state
// encoding and the counter-width helper.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    PRESENT,
    SHIFT,
    DONE
  } state_t;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_readout_sequencer_counter.sv
// Modulo-N up counter with synchronous clear; used for word and row indices.
module readout_counter
  import readout_pkg::*;
#(
  parameter int modulus = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            inc,
  output logic [cnt_width(modulus)-1:0]   count,
  output logic                            at_max
);

  localparam int w = cnt_width(modulus);
  localparam logic [w-1:0] max_val = w'(modulus - 1);

  assign at_max = (count == max_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + w'(1);
    end
  end

endmodule

// File: rtl/pixel_readout_sequencer.sv
// Sequencer that drives a RegisterShifter row buffer and streams its words out.
// Optional sticky overrun flag for starts outside IDLE: define OVERRUN_DETECT_EN.
module pixel_readout_sequencer
  import readout_pkg::*;
#(
  parameter int bits   = 4,
  parameter int length = 4,
  parameter int rows   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          reg_set,
  output logic                          reg_set_select,
  output logic                          reg_shift,
  output logic                          reg_reset,
  input  logic [bits-1:0]               reg_data,
  output logic [bits-1:0]               out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [cnt_width(rows)-1:0]    out_row,
  output logic                          frame_done,
  output state_t                        fsm_state
`ifdef OVERRUN_DETECT_EN
  ,
  output logic                          overrun
`endif
);

  localparam int ww = cnt_width(length);
  localparam logic [ww-1:0] word_last = ww'(length - 1);

  state_t state, next;
  logic [ww-1:0] word_cnt;
  logic [cnt_width(rows)-1:0] row_cnt;
  logic word_at_max, row_at_max;
  logic word_inc, word_clear, row_inc;

  assign fsm_state  = state;
  assign word_inc   = (state == PRESENT) && out_ready && !word_at_max;
  assign word_clear = (state == DONE);
  assign row_inc    = (state == DONE);

  readout_counter #(.modulus(length)) u_word_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (word_clear),
    .inc    (word_inc),
    .count  (word_cnt),
    .at_max (word_at_max)
  );

  readout_counter #(.modulus(rows)) u_row_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .inc    (row_inc),
    .count  (row_cnt),
    .at_max (row_at_max)
  );

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_data/out_last/out_row hold while out_valid waits, out_ready alone does nothing.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = LOAD;
      LOAD:    next = SETTLE;
      SETTLE:  next = CAPTURE;
      CAPTURE: next = PRESENT;
      PRESENT: if (out_ready) next = out_last ? DONE : SHIFT;
      SHIFT:   next = SETTLE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered so the
  // edge-sensitive shifter only ever sees clean single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      reg_set        <= 1'b0;
      reg_set_select <= 1'b0;
      reg_shift      <= 1'b0;
      reg_reset      <= 1'b1;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      out_row        <= '0;
      frame_done     <= 1'b0;
    end else begin
      state          <= next;
      busy           <= (next != IDLE);
      reg_set        <= (next == LOAD);
      reg_set_select <= (next == LOAD) || ((next == SETTLE) && (state == LOAD));
      reg_shift      <= (next == SHIFT);
      reg_reset      <= (next == DONE);
      out_valid      <= (next == PRESENT);
      frame_done     <= (next == DONE) && row_at_max;
      if (state == CAPTURE) begin
        out_data <= reg_data;
        out_last <= (word_cnt == word_last);
        out_row  <= row_cnt;
      end
    end
  end

`ifdef OVERRUN_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (start && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// Bench for pixel_readout_sequencer driving a behavioural RegisterShifter;
// random rows and ready stalls are scored against a word-queue model.
module tb_pixel_readout_sequencer;
  import readout_pkg::*;

  localparam int BITS   = 4;
  localparam int LENGTH = 4;
  localparam int ROWS   = 2;
  localparam int RW     = cnt_width(ROWS);
  localparam int EW     = RW + 1 + BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, reg_set, reg_set_select, reg_shift, reg_reset;
  logic out_valid, out_last, frame_done;
  logic [BITS-1:0] reg_data, out_data;
  logic [RW-1:0] out_row;
  state_t fsm_state;
`ifdef OVERRUN_DETECT_EN
  logic overrun;
`endif

  logic [BITS*LENGTH-1:0] data_in = '0;
  logic [BITS*LENGTH-1:0] sh;

  logic [EW-1:0] exp_q[$];
  int acc_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int row_acc = 0;
  int fd_count = 0;
  int mdl_row = 0;
  int ready_mode = 0;
  bit fd_due = 1'b0;
  bit prev_strobe = 1'b0;

  pixel_readout_sequencer #(.bits(BITS), .length(LENGTH), .rows(ROWS)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .reg_set        (reg_set),
    .reg_set_select (reg_set_select),
    .reg_shift      (reg_shift),
    .reg_reset      (reg_reset),
    .reg_data       (reg_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .out_row        (out_row),
    .frame_done     (frame_done),
`ifdef OVERRUN_DETECT_EN
    .overrun        (overrun),
`endif
    .fsm_state      (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RegisterShifter: load whole row, shift toward word 0
  always @(posedge clk or posedge reg_reset) begin
    if (reg_reset) sh <= '0;
    else if (reg_set && reg_set_select) sh <= data_in;
    else if (reg_shift) sh <= sh >> BITS;
  end
  assign reg_data = sh[BITS-1:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: a row is its words low nibble first, tagged by row number
  task automatic push_row(input logic [BITS*LENGTH-1:0] d);
    logic [BITS-1:0] w;
    for (int i = 0; i < LENGTH; i++) begin
      w = d[i*BITS +: BITS];
      exp_q.push_back({RW'(mdl_row), (i == LENGTH - 1), w});
    end
    mdl_row = (mdl_row + 1) % ROWS;
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // scoreboard and strobe monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      fd_due = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      check("frame_done", frame_done, fd_due);
      if (frame_done) fd_count++;
      fd_due = 1'b0;
      if (reg_set || reg_shift) check("strobe_gap", prev_strobe, 0);
      prev_strobe = reg_set || reg_shift;
      if (reg_set) check("set_select_on_set", reg_set_select, 1);
      if (out_valid) check("no_shift_while_valid", reg_shift, 0);
      if (out_valid && out_ready) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[BITS-1:0]);
          check("out_last", out_last, e[BITS]);
          check("out_row", out_row, e[EW-1:BITS+1]);
          if (e[BITS] && (e[EW-1:BITS+1] == RW'(ROWS - 1))) fd_due = 1'b1;
        end
        acc_q.push_back(cyc);
        row_acc++;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_reg_set", reg_set, 0);
    check("rst_reg_set_select", reg_set_select, 0);
    check("rst_reg_shift", reg_shift, 0);
    check("rst_reg_reset", reg_reset, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_row", out_row, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", fsm_state, IDLE);
`ifdef OVERRUN_DETECT_EN
    check("rst_overrun", overrun, 0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    mdl_row = 0;
    row_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    check("reg_reset_held", reg_reset, 1);
    @(posedge clk);
    #1;
    check("reg_reset_release", reg_reset, 0);
  endtask

  task automatic start_row(input logic [BITS*LENGTH-1:0] d);
    int n;
    data_in = d;
    push_row(d);
    row_acc = 0;
    acc_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_latency", n, 4);
  endtask

  task automatic wait_acc(input int cnt, input int budget);
    for (int i = 0; i < budget && row_acc < cnt; i++) begin
      @(posedge clk);
      #1;
    end
    check("accept_in_time", row_acc >= cnt, 1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("valid_in_time", out_valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy || exp_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("idle_in_time", !busy && exp_q.size() == 0, 1);
  endtask

  initial begin
    int fd0;
    do_reset();

    // single row, ready held high
    ready_mode = 0;
    start_row(16'h4321);
    wait_acc(4, 60);
    check("done_reg_reset", reg_reset, 1);
    check("done_busy", busy, 1);
    @(posedge clk);
    #1;
    check("idle_reg_reset", reg_reset, 0);
    check("idle_busy", busy, 0);
    check("accept_count", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++) check("word_spacing", acc_q[i] - acc_q[i-1], 4);

    // two rows make one frame, then the row index wraps
    do_reset();
    fd0 = fd_count;
    start_row(16'hA5C3);
    wait_idle(100);
    start_row(16'h1234);
    wait_idle(100);
    check("frame_done_count", fd_count - fd0, 1);
    start_row(16'h0F0F);
    wait_idle(100);

    // consumer stalls on word 2
    do_reset();
    ready_mode = 0;
    start_row(16'h4321);
    wait_acc(1, 40);
    ready_mode = 2;
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 4'h2);
    end
    ready_mode = 0;
    @(posedge clk);
    #1;
    wait_idle(100);

    // asynchronous reset while word 3 is presented
    start_row(16'h8765);
    wait_acc(2, 60);
    ready_mode = 2;
    wait_valid(20);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    mdl_row = 0;
    row_acc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_reg_reset", reg_reset, 1);
    @(posedge clk);
    #1;
    ready_mode = 0;
    start_row(16'hCBA9);
    wait_idle(100);

    // stray start during word 2
    start_row(16'h3C5A);
    wait_acc(1, 40);
    wait_valid(20);
`ifdef OVERRUN_DETECT_EN
    check("overrun_before", overrun, 0);
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef OVERRUN_DETECT_EN
    check("overrun_set", overrun, 1);
`endif
    wait_idle(100);
    check("overrun_row_words", row_acc, 4);

    // random rows with random backpressure
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      start_row(16'($urandom));
      wait_idle(400);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef OVERRUN_DETECT_EN
    check("overrun_sticky", overrun, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
